// File: rtl/rca_pkg.sv
// Shared definitions for the sequential nibble-serial ripple-carry adder:
// state encoding, slice width and the counter-width helper.
package rca_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed to count WIDTH/4 nibbles; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width / NIB_W <= 2) ? 1 : $clog2(width / NIB_W);
  endfunction

endpackage

// File: rtl/rca64_seq_adder_fa4bit.sv
// FA4bit: 4-bit ripple-carry adder slice built from four full adders.
module FA4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[4];

endmodule

// File: rtl/rca64_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one FA4bit slice processes a nibble per clock,
// with valid/ready handshakes on the operand and result sides.
module rca64_seq_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(WIDTH / NIB_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;

  logic [NIB_W-1:0]   nib_sum;
  logic               nib_cout;

  // Operands are shifted right every RUN cycle, so the slice always sees bits [3:0].
  FA4bit u_slice (
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0]),
    .cin  (carry_q),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> NIB_W;
        b_d     = b_q >> NIB_W;
        sum_d   = {nib_sum, sum_q[WIDTH-1:NIB_W]};
        carry_d = nib_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_NIB) begin
          c_out_d = nib_cout;
          ovf_d   = (sa_q == sb_q) && (nib_sum[NIB_W-1] != sa_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca64_seq_adder.sv
// Directed and random checks of rca64_seq_adder: arithmetic, latency,
// result hold under backpressure, mid-operation reset and back-to-back throughput.
module tb_rca64_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        c_out;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rca64_seq_adder #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Sampling is done 1 time unit after a rising edge throughout.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                       input logic tc, input logic [63:0] es, input logic ec, input logic eo);
    int lat;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd16);
    check({tag, "_sum"}, sum, es);
    check({tag, "_c_out"}, 64'(c_out), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    int lat;
    int seen;
    int acc_prev;
    logic [63:0] ea, eb;
    logic        ec;
    logic [64:0] ref_full;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_hs", 64'({in_ready, out_valid}), 64'b10);
    check("reset_sum", sum, 64'd0);
    check("reset_flags", 64'({c_out, ovf}), 64'd0);

    do_op("all_ones_p1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    do_op("max_pos_p1",  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    do_op("min_neg_x2",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
    do_op("cin_only",    64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0);
    do_op("pattern",     64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1, 1'b0);
    do_op("small",       64'h5, 64'h7, 1'b0, 64'hC, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles, new in_valid ignored.
    a = 64'h5; b = 64'h7; c_in = 1'b1; in_valid = 1'b1;
    tick();
    a = 64'h1111; b = 64'h2222; c_in = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("hold_latency", 64'(lat), 64'd16);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_sum_%0d", i), sum, 64'hD);
      check($sformatf("hold_hs_%0d", i), 64'({in_ready, out_valid, c_out, ovf}), 64'b0100);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_idle", 64'({in_ready, out_valid}), 64'b10);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("hold_no_ghost", 64'(seen), 64'd0);

    // Reset mid-RUN when cnt == 8: operation is discarded.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; c_in = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_hs", 64'({in_ready, out_valid}), 64'b10);
    check("abort_sum", sum, 64'd0);
    check("abort_flags", 64'({c_out, ovf}), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("abort_no_result", 64'(seen), 64'd0);

    // Back-to-back random operands with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom);
    acc_prev = 0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("b2b_ready_%0d", k), 64'(in_ready), 64'd1);
      tick();
      ea = a; eb = b; ec = c_in;
      if (k > 0) check($sformatf("b2b_spacing_%0d", k), 64'(cyc - acc_prev), 64'd18);
      acc_prev = cyc;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
        tick();
        lat++;
      end
      ref_full = {1'b0, ea} + {1'b0, eb} + {64'd0, ec};
      check($sformatf("b2b_sum_%0d", k), sum, ref_full[63:0]);
      check($sformatf("b2b_c_out_%0d", k), 64'(c_out), 64'(ref_full[64]));
      check($sformatf("b2b_ovf_%0d", k), 64'(ovf),
            64'((ea[63] == eb[63]) && (ref_full[63] != ea[63])));
      lat = 0;
      while (!in_ready && lat < 40) begin
        tick();
        lat++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
